timer_sched: RTL and testbench
==============================

Name: timer_sched

Overview:
- Time-shares the single `timer` instance among N_REQ requesters. Each requester asks for a one-shot delay of a given period.
- Arbitrates round-robin, programs the timer in up-count mode (MODE=2'b01), waits for its IRT pulse, then stops the timer and signals completion to the granted requester.
- Sits between the requester blocks and the `TACCR`/`MODE`/`IRT` interface of `timer`.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 16, period width; must equal the timer's TACCR width

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- REQ  in  N_REQ  level request per requester; held until DONE or ERR
- PERIOD  in  N_REQ*W  period for requester i in bits [i*W +: W]; sampled at grant
- GNT  out  N_REQ  one-hot; high while requester i owns the timer
- DONE  out  N_REQ  one-cycle pulse: delay for requester i elapsed
- ERR  out  N_REQ  one-cycle pulse: request rejected (PERIOD==0)
- BUSY  out  1  high in any state other than IDLE
- TACCR  out  W  to timer; registered
- MODE  out  2  to timer; registered
- IRT  in  1  from timer; one-cycle pulse

Behaviour:
- Reset (async, RST_N low): state=IDLE, GNT=0, DONE=0, ERR=0, BUSY=0, TACCR=0, MODE=2'b00, round-robin pointer=0. Takes effect immediately, including mid-RUN; the timer stops on the next edge because TACCR=0.
- All outputs are registered.
- States: IDLE, RUN, REL.
- IDLE:
  - Select the first i with REQ[i]=1, searching from pointer upward with wrap.
  - If PERIOD[i]==0: ERR[i] pulses for one cycle, pointer=i+1 mod N_REQ, stay IDLE.
  - Else, at the next edge: GNT[i]=1, TACCR=PERIOD[i] (latched), MODE=2'b01, BUSY=1, state=RUN.
  - If no REQ: nothing happens.
- RUN:
  - Hold TACCR and MODE stable.
  - IRT=1 -> next edge: DONE[i]=1 for one cycle, GNT=0, TACCR=0, MODE=2'b00, state=REL.
  - REQ[i] dropped (abort) -> same transition, but DONE is not pulsed.
  - IRT and the REQ drop in the same cycle -> treated as completion; DONE pulses.
- REL:
  - Exactly one cycle with TACCR=0 and MODE=0, so the timer stops and clears its counter before the next arm.
  - pointer=i+1 mod N_REQ, state=IDLE, BUSY=0 at the next edge.
- IRT outside RUN is ignored.
- Changes to PERIOD[i] after grant are ignored.
- Minimum gap between consecutive grants: 2 cycles (REL, then IDLE arbitration).
- Timing with the `timer` model: the timer loads on the edge after GNT rises. DONE rises P+3 cycles after GNT rises for period P.
- Requester obligation: hold REQ[i] until DONE or ERR. A requester that re-asserts REQ in the cycle after DONE is treated as a new request.
- Pointer arithmetic is modulo N_REQ. N_REQ need not be a power of two.

Decomposition:
- Package `timer_pkg`:
  - timer mode encodings: MODE_STOP=2'b00, MODE_UP=2'b01, MODE_CONT=2'b10, MODE_UPDOWN=2'b11
  - default width constant TMR_W=16
  - sched state enum {IDLE, RUN, REL}
- Sub-module `rr_arbiter` (parameter N): combinational round-robin pick.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, valid.

Test Plan:
- Single request: REQ[0]=1, PERIOD[0]=5 -> GNT=4'b0001 and TACCR=5, MODE=01 one cycle later; DONE[0] pulses 8 cycles after GNT rises; then one REL cycle with TACCR=0/MODE=0; BUSY low afterwards.
- Round-robin: REQ=4'b1111, all periods=3 -> grant order 0,1,2,3,0; each DONE 6 cycles after its GNT; 2-cycle gap between grants.
- Zero period: REQ[2]=1, PERIOD[2]=0 -> ERR[2] one-cycle pulse, GNT stays 0, TACCR stays 0; a concurrent REQ[3] (PERIOD=4) is granted next.
- Abort: REQ[1] dropped 3 cycles into RUN (PERIOD=10) -> no DONE[1]; REL cycle; next requester granted; the timer's counter is cleared before the new load.
- Async reset mid-RUN: RST_N low between edges -> all outputs 0 immediately; after release, REQ[0] with PERIOD=2 completes with DONE 5 cycles after GNT.
- Spurious IRT in IDLE/REL and PERIOD change after grant -> no DONE; the period latched at grant is used.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for the timer and its scheduler: mode codes, default width, FSM states.
package timer_pkg;

    localparam logic [1:0] MODE_STOP   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;
    localparam logic [1:0] MODE_UPDOWN = 2'b11;

    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REL  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the pointer, with wrap.
module rr_arbiter
    import timer_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Walk the requests starting at the pointer; the modulo is an explicit subtract so N need not be a power of two.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] j;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            j = sum[IW-1:0];
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                idx_o    = j;
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Time-shares one up-counting timer among N_REQ one-shot delay requesters, round-robin.
module timer_sched
    import timer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = TMR_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ*W-1:0] PERIOD,
    output logic [N_REQ-1:0]   GNT,
    output logic [N_REQ-1:0]   DONE,
    output logic [N_REQ-1:0]   ERR,
    output logic               BUSY,
    output logic [W-1:0]       TACCR,
    output logic [1:0]         MODE,
    input  logic               IRT
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_e     state_q, state_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [PW-1:0]    own_q,   own_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [N_REQ-1:0] done_q,  done_d;
    logic [N_REQ-1:0] err_q,   err_d;
    logic             busy_q,  busy_d;
    logic [W-1:0]     taccr_q, taccr_d;
    logic [1:0]       mode_q,  mode_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_vld;
    logic [W-1:0]     per_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_per
        assign per_a[g] = PERIOD[g*W +: W];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
        return (i == PW'(N_REQ - 1)) ? '0 : i + PW'(1);
    endfunction

    // Next-state and registered-output logic for the IDLE/RUN/REL sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        busy_d  = busy_q;
        taccr_d = taccr_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    if (per_a[arb_idx] == '0) begin
                        // A zero period can never fire; reject it and move past this requester.
                        err_d = arb_gnt;
                        ptr_d = ptr_inc(arb_idx);
                    end else begin
                        gnt_d   = arb_gnt;
                        own_d   = arb_idx;
                        taccr_d = per_a[arb_idx];
                        mode_d  = MODE_UP;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // IRT wins over a simultaneous REQ drop, so the requester still sees DONE.
                if (IRT || !REQ[own_q]) begin
                    done_d  = IRT ? gnt_q : '0;
                    gnt_d   = '0;
                    taccr_d = '0;
                    mode_d  = MODE_STOP;
                    state_d = REL;
                end
            end
            REL: begin
                // One stopped cycle lets the timer clear its counter before the next arm.
                ptr_d   = ptr_inc(own_q);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset forces TACCR=0 so the timer stops on its next edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            taccr_q <= '0;
            mode_q  <= MODE_STOP;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            taccr_q <= taccr_d;
            mode_q  <= mode_d;
        end
    end

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign BUSY  = busy_q;
    assign TACCR = taccr_q;
    assign MODE  = mode_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: behavioural timer plus a round-robin reference model.
module tb_timer_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int PW = 2;

    logic           CLK   = 1'b0;
    logic           RST_N = 1'b1;
    logic [N-1:0]   REQ   = '0;
    logic [N*W-1:0] PERIOD;
    logic [N-1:0]   GNT, DONE, ERR;
    logic           BUSY;
    logic [W-1:0]   TACCR;
    logic [1:0]     MODE;
    logic           IRT;

    logic [W-1:0] per_r [N];
    logic         irt_m   = 1'b0;
    logic         irt_inj = 1'b0;
    int unsigned  tcnt    = 0;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    for (genvar g = 0; g < N; g++) begin : g_per
        assign PERIOD[g*W +: W] = per_r[g];
    end

    assign IRT = irt_m | irt_inj;

    timer_sched #(.N_REQ(N), .W(W)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .REQ    (REQ),
        .PERIOD (PERIOD),
        .GNT    (GNT),
        .DONE   (DONE),
        .ERR    (ERR),
        .BUSY   (BUSY),
        .TACCR  (TACCR),
        .MODE   (MODE),
        .IRT    (IRT)
    );

    always #5 CLK = ~CLK;

    // Timer: cleared while stopped; in up mode it loads on the first edge, counts TACCR, then pulses IRT.
    always @(posedge CLK) begin
        if (MODE == 2'b01) begin
            tcnt  <= tcnt + 1;
            irt_m <= ((tcnt + 1) == (32'(TACCR) + 2));
        end else begin
            tcnt  <= 0;
            irt_m <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    // Reference arbitration: first pending requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[PW'((p + k) % N)]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_evt(output int n);
        tick();
        n = 1;
        while ((GNT | ERR) == '0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One arbitration round from IDLE: either a rejection or a full grant-to-release sequence.
    task automatic do_step(input bit chg, input bit spur, output int who);
        int i;
        int n;
        logic [W-1:0] p;
        i   = pick(REQ, ptr_m);
        who = i;
        if (i < 0) begin
            check("pick_valid", 32'(i), 0);
            return;
        end
        p = per_r[PW'(i)];
        wait_evt(n);
        check("evt_latency", 32'(n), 1);
        if (p == '0) begin
            check("err_vec",   32'(ERR),   oh(i));
            check("err_gnt",   32'(GNT),   0);
            check("err_taccr", 32'(TACCR), 0);
            check("err_busy",  32'(BUSY),  0);
            REQ[PW'(i)] = 1'b0;
        end else begin
            check("gnt_vec",   32'(GNT),   oh(i));
            check("gnt_taccr", 32'(TACCR), 32'(p));
            check("gnt_mode",  32'(MODE),  1);
            check("gnt_busy",  32'(BUSY),  1);
            check("gnt_err",   32'(ERR),   0);
            if (chg) per_r[PW'(i)] = p + 16'd7;
            n = 0;
            do begin
                tick();
                n++;
                if (DONE == '0) check("run_taccr", 32'(TACCR), 32'(p));
            end while (DONE == '0 && n < 300);
            check("done_lat",  32'(n),     32'(p) + 3);
            check("done_vec",  32'(DONE),  oh(i));
            check("rel_gnt",   32'(GNT),   0);
            check("rel_taccr", 32'(TACCR), 0);
            check("rel_mode",  32'(MODE),  0);
            check("rel_busy",  32'(BUSY),  1);
            REQ[PW'(i)] = 1'b0;
            if (spur) irt_inj = 1'b1;
            tick();
            irt_inj = 1'b0;
            check("done_clr",  32'(DONE),  0);
            check("idle_busy", 32'(BUSY),  0);
            check("idle_gnt",  32'(GNT),   0);
        end
        ptr_m = (i + 1) % N;
    endtask

    initial begin
        int who;
        int n;
        int i;
        int other;
        int guard;
        logic [N-1:0] ra;

        for (int k = 0; k < N; k++) per_r[k] = '0;

        // Reset state
        #1 RST_N = 1'b0;
        #1;
        check("rst_gnt",   32'(GNT),   0);
        check("rst_done",  32'(DONE),  0);
        check("rst_err",   32'(ERR),   0);
        check("rst_busy",  32'(BUSY),  0);
        check("rst_taccr", 32'(TACCR), 0);
        check("rst_mode",  32'(MODE),  0);
        tick();
        tick();
        RST_N = 1'b1;
        ptr_m = 0;
        tick();

        // Zero period on requester 2 is rejected; concurrent requester 3 is granted next
        per_r[2] = 16'd0;
        per_r[3] = 16'd4;
        REQ = 4'b1100;
        do_step(1'b0, 1'b0, who);
        check("zero_who", 32'(who), 2);
        do_step(1'b0, 1'b0, who);
        check("zero_next", 32'(who), 3);

        // Single request, period 5
        per_r[0] = 16'd5;
        REQ = 4'b0001;
        do_step(1'b0, 1'b0, who);

        // Round-robin with all four requesting, random periods, re-asserting after each DONE
        for (int k = 0; k < N; k++) per_r[k] = W'($urandom_range(1, 6));
        REQ = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            i = pick(REQ, ptr_m);
            do_step(1'b0, 1'b0, who);
            check("rr_order", 32'(who), 32'(i));
            REQ[PW'(who)] = 1'b1;
        end
        REQ = '0;
        tick();
        check("rr_idle", 32'(BUSY), 0);

        // Abort: the granted requester drops REQ three cycles into RUN
        ra = 4'b0110;
        i = pick(ra, ptr_m);
        other = (i == 1) ? 2 : 1;
        per_r[PW'(i)] = 16'd10;
        per_r[PW'(other)] = W'($urandom_range(1, 6));
        REQ = ra;
        wait_evt(n);
        check("abort_lat", 32'(n), 1);
        check("abort_gnt", 32'(GNT), oh(i));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_run_done", 32'(DONE), 0);
        end
        REQ[PW'(i)] = 1'b0;
        tick();
        check("abort_done",  32'(DONE),  0);
        check("abort_gnt0",  32'(GNT),   0);
        check("abort_taccr", 32'(TACCR), 0);
        check("abort_mode",  32'(MODE),  0);
        check("abort_busy",  32'(BUSY),  1);
        ptr_m = (i + 1) % N;
        tick();
        check("abort_idle", 32'(BUSY), 0);
        do_step(1'b0, 1'b0, who);
        check("abort_next", 32'(who), 32'(other));

        // Spurious IRT in IDLE, then PERIOD change after grant and spurious IRT in REL
        irt_inj = 1'b1;
        tick();
        irt_inj = 1'b0;
        check("spur_idle_done", 32'(DONE), 0);
        check("spur_idle_busy", 32'(BUSY), 0);
        tick();
        check("spur_idle_done2", 32'(DONE), 0);
        per_r[1] = 16'd3;
        REQ = 4'b0010;
        do_step(1'b1, 1'b1, who);

        // Async reset in the middle of RUN
        per_r[3] = 16'd9;
        REQ = 4'b1000;
        wait_evt(n);
        check("ar_gnt", 32'(GNT), oh(3));
        tick();
        tick();
        #3;
        RST_N = 1'b0;
        #1;
        check("ar_gnt0",  32'(GNT),   0);
        check("ar_taccr", 32'(TACCR), 0);
        check("ar_mode",  32'(MODE),  0);
        check("ar_busy",  32'(BUSY),  0);
        check("ar_done",  32'(DONE),  0);
        check("ar_err",   32'(ERR),   0);
        REQ = '0;
        tick();
        RST_N = 1'b1;
        ptr_m = 0;
        tick();
        per_r[0] = 16'd2;
        REQ = 4'b0001;
        do_step(1'b0, 1'b0, who);

        // Random request sets, periods including zero, drained through the reference model
        for (int r = 0; r < 8; r++) begin
            REQ = '0;
            ra = N'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) per_r[k] = W'($urandom_range(0, 5));
            REQ = ra;
            guard = 0;
            while (REQ != '0 && guard < 8) begin
                do_step(1'b0, 1'b0, who);
                guard++;
            end
            tick();
            check("rnd_done_clr", 32'(DONE), 0);
            check("rnd_err_clr",  32'(ERR),  0);
            check("rnd_busy",     32'(BUSY), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
